divisor_secuencial: RTL and testbench

//   Iterative signed integer divider, the inverse operation of the team's signed

---
 rtl/divisor_secuencial.sv | 187 ++++++++++++++++++
 tb/tb_divisor_secuencial.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// -----------------------------------------------------------------------------
// divisor_secuencial
//   Iterative signed integer divider (restoring algorithm, one quotient bit per
//   clock). Computes Q = A / B truncated toward zero and R = A - Q*B, with the
//   remainder taking the sign of A. Every division takes exactly n+1 edges from
//   acceptance to the completing edge, whatever the operand values.
//
// Parameters
//   n : dividend / quotient width (signed two's complement), n >= 2
//   m : divisor / remainder width (signed two's complement), 2 <= m <= n
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active high
//   start : request pulse, accepted only while busy = 0
//   A, B  : signed dividend / divisor, sampled at the accepting edge only
//   Q, R  : signed quotient / remainder, held until the next completion
//   busy  : a division is in progress
//   done  : one-cycle pulse; Q/R/div0/ovf are valid from this cycle
//   div0  : last result was a division by zero
//   ovf   : last result overflowed (A = -2^(n-1), B = -1)
// -----------------------------------------------------------------------------
module divisor_secuencial #(
  parameter int n = 16,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [m-1:0] B,
  output logic [n-1:0] Q,
  output logic [m-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic         ovf
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Shared shift register: starts as |A| and, as its MSBs are consumed into
  // the partial remainder, fills from the LSB with quotient bits. |A| is at
  // most 2^(n-1), which is representable as an n-bit unsigned value.
  logic [n-1:0]   dq_q, dq_d;
  // Partial remainder stays below |B| <= 2^(m-1), so m bits hold it.
  logic [m-1:0]   rem_q, rem_d;
  logic [m:0]     b_mag_q, b_mag_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           zero_q, zero_d;
  logic           wrap_q, wrap_d;
  logic [n-1:0]   q_q, q_d;
  logic [m-1:0]   r_q, r_d;
  logic           done_q, done_d;
  logic           div0_q, div0_d;
  logic           ovf_q, ovf_d;

  logic [m:0]     shifted;
  logic           fits;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    b_mag_d = b_mag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    wrap_d  = wrap_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // Trial subtraction of the restoring step.
    shifted = {rem_q, dq_q[n-1]};
    fits    = (shifted >= b_mag_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ITER;
          cnt_d   = '0;
          rem_d   = '0;
          dq_d    = A[n-1] ? -A : A;
          b_mag_d = B[m-1] ? -{B[m-1], B} : {1'b0, B};
          qneg_d  = A[n-1] ^ B[m-1];
          rneg_d  = A[n-1];
          zero_d  = (B == '0);
          wrap_d  = (A == {1'b1, {(n-1){1'b0}}}) && (B == '1);
        end
      end

      S_ITER: begin
        if (fits) begin
          rem_d = m'(shifted - b_mag_q);
          dq_d  = {dq_q[n-2:0], 1'b1};
        end else begin
          rem_d = shifted[m-1:0];
          dq_d  = {dq_q[n-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n - 1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (zero_q) begin
          // Iteration output is meaningless with |B| = 0; report zeros.
          q_d    = '0;
          r_d    = '0;
          div0_d = 1'b1;
          ovf_d  = 1'b0;
        end else if (wrap_q) begin
          // +2^(n-1) does not fit; the wrapped value is -2^(n-1).
          q_d    = {1'b1, {(n-1){1'b0}}};
          r_d    = '0;
          div0_d = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          q_d    = qneg_q ? -dq_q : dq_q;
          r_d    = rneg_q ? -rem_q : rem_q;
          div0_d = 1'b0;
          ovf_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      b_mag_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      wrap_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      b_mag_q <= b_mag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      wrap_q  <= wrap_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// -----------------------------------------------------------------------------
// tb_divisor_secuencial
//   Directed bench for divisor_secuencial (n=16, m=8): reset state, signed
//   quotient/remainder cases, division by zero, overflow, ignored and
//   back-to-back starts, mid-division reset and a random sweep with latency
//   checks. Inputs change 1 time unit after rising edges; outputs are sampled
//   at the same point.
// -----------------------------------------------------------------------------
module tb_divisor_secuencial;

  localparam int N   = 16;
  localparam int M   = 8;
  localparam int LAT = N + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic [N-1:0] q;
  logic [M-1:0] r;
  logic         busy;
  logic         done;
  logic         div0;
  logic         ovf;

  int tests;
  int fails;

  divisor_secuencial #(.n(N), .m(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Q     (q),
    .R     (r),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with start for one edge (E0); returns 1 unit after E0.
  task automatic issue(input logic [N-1:0] av, input logic [M-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; returns -1 if the bound expires.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({q, r, busy, done, div0, ovf} !== '0) begin
      $display("FAIL reset: q=%0h r=%0h busy=%b done=%b div0=%b ovf=%b, want all 0",
               q, r, busy, done, div0, ovf);
      fails++;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int e;
    issue(16'd1000, 8'd7);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL basic_busy: busy=%b done=%b, want 1 0", busy, done);
      fails++;
    end
    wait_done(e);
    tests++;
    if (e !== LAT) begin
      $display("FAIL basic_latency: %0d edges, want %0d", e, LAT);
      fails++;
    end
    tests++;
    if ({q, r, div0, ovf, busy} !== {16'd142, 8'd6, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL basic_result: q=%0d r=%0d div0=%b ovf=%b busy=%b, want 142 6 0 0 0",
               $signed(q), $signed(r), div0, ovf, busy);
      fails++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || q !== 16'd142 || r !== 8'd6) begin
      $display("FAIL basic_hold: done=%b q=%0d r=%0d, want 0 142 6", done, $signed(q), $signed(r));
      fails++;
    end
  endtask

  task automatic test_signs;
    logic [N-1:0] av [3];
    logic [M-1:0] bv [3];
    logic [N-1:0] eq [3];
    logic [M-1:0] er [3];
    int e;
    av = '{-16'sd1000, 16'sd1000, -16'sd1000};
    bv = '{8'sd7, -8'sd7, -8'sd7};
    eq = '{-16'sd142, -16'sd142, 16'sd142};
    er = '{-8'sd6, 8'sd6, -8'sd6};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i]);
      wait_done(e);
      tests++;
      if (e !== LAT || {q, r, div0, ovf} !== {eq[i], er[i], 1'b0, 1'b0}) begin
        $display("FAIL signs_%0d: edges=%0d q=%0d r=%0d div0=%b ovf=%b, want %0d %0d %0d 0 0",
                 i, e, $signed(q), $signed(r), div0, ovf, LAT, $signed(eq[i]), $signed(er[i]));
        fails++;
      end
    end
  endtask

  task automatic test_div0;
    int e;
    issue(16'd1234, 8'd0);
    wait_done(e);
    tests++;
    if (e !== LAT || {q, r, div0, ovf} !== {16'd0, 8'd0, 1'b1, 1'b0}) begin
      $display("FAIL div0: edges=%0d q=%0d r=%0d div0=%b ovf=%b, want %0d 0 0 1 0",
               e, $signed(q), $signed(r), div0, ovf, LAT);
      fails++;
    end
  endtask

  task automatic test_ovf;
    int e;
    issue(16'h8000, 8'hFF);
    wait_done(e);
    tests++;
    if (e !== LAT || {q, r, div0, ovf} !== {16'h8000, 8'd0, 1'b0, 1'b1}) begin
      $display("FAIL ovf: edges=%0d q=%0d r=%0d div0=%b ovf=%b, want %0d -32768 0 0 1",
               e, $signed(q), $signed(r), div0, ovf, LAT);
      fails++;
    end
    issue(16'h8000, 8'd1);
    wait_done(e);
    tests++;
    if (e !== LAT || {q, r, div0, ovf} !== {16'h8000, 8'd0, 1'b0, 1'b0}) begin
      $display("FAIL min_div_1: edges=%0d q=%0d r=%0d div0=%b ovf=%b, want %0d -32768 0 0 0",
               e, $signed(q), $signed(r), div0, ovf, LAT);
      fails++;
    end
  endtask

  task automatic test_ignored_start;
    int e;
    int seen;
    issue(16'd1000, 8'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    a     = 16'd5;
    b     = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(e);
    tests++;
    if (e !== LAT - 5 || q !== 16'd142 || r !== 8'd6) begin
      $display("FAIL ignored_start: edges=%0d q=%0d r=%0d, want %0d 142 6",
               (e < 0) ? e : e + 5, $signed(q), $signed(r), LAT);
      fails++;
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      $display("FAIL no_queue: %0d cycles busy/done after ignored start, want 0", seen);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    int e;
    issue(-16'sd1000, -8'sd7);
    wait_done(e);
    tests++;
    if (e !== LAT || q !== 16'd142 || r !== -8'sd6) begin
      $display("FAIL b2b_first: edges=%0d q=%0d r=%0d, want %0d 142 -6",
               e, $signed(q), $signed(r), LAT);
      fails++;
    end
    issue(16'd300, -8'sd11);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 16'd142) begin
      $display("FAIL b2b_accept: busy=%b done=%b q=%0d, want 1 0 142", busy, done, $signed(q));
      fails++;
    end
    wait_done(e);
    tests++;
    if (e !== LAT || q !== -16'sd27 || r !== 8'd3) begin
      $display("FAIL b2b_second: edges=%0d q=%0d r=%0d, want %0d -27 3",
               e, $signed(q), $signed(r), LAT);
      fails++;
    end
  endtask

  task automatic test_reset_mid;
    int e;
    int seen;
    issue(16'd1000, 8'd7);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({q, r, busy, done, div0, ovf} !== '0) begin
      $display("FAIL reset_mid: q=%0d r=%0d busy=%b done=%b div0=%b ovf=%b, want all 0",
               $signed(q), $signed(r), busy, done, div0, ovf);
      fails++;
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      $display("FAIL reset_no_done: %0d cycles busy/done after reset, want 0", seen);
      fails++;
    end
    issue(16'd100, -8'sd3);
    wait_done(e);
    tests++;
    if (e !== LAT || {q, r, div0, ovf} !== {-16'sd33, 8'd1, 1'b0, 1'b0}) begin
      $display("FAIL after_reset: edges=%0d q=%0d r=%0d div0=%b ovf=%b, want %0d -33 1 0 0",
               e, $signed(q), $signed(r), div0, ovf, LAT);
      fails++;
    end
  endtask

  task automatic test_sweep;
    logic signed [N-1:0] sa;
    logic signed [M-1:0] sb;
    logic signed [N-1:0] eq;
    logic signed [N-1:0] er;
    int e;
    for (int i = 0; i < 2000; i++) begin
      sa = N'($urandom);
      sb = M'($urandom);
      if (sb == 0) sb = 8'sd1;
      if (sa == 16'sh8000 && sb == -8'sd1) sb = 8'sd3;
      eq = sa / sb;
      er = sa % sb;
      issue(sa, sb);
      wait_done(e);
      tests++;
      if (e !== LAT || q !== eq || r !== er[M-1:0] || div0 !== 1'b0 || ovf !== 1'b0) begin
        $display("FAIL sweep_%0d: A=%0d B=%0d edges=%0d q=%0d r=%0d, want %0d %0d %0d",
                 i, sa, sb, e, $signed(q), $signed(r), LAT, eq, er);
        fails++;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div0();
    test_ovf();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
